// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the request-vector priority encoder.
// Holds the FSM state type, the default vector width and the index-width helper.
package req_enc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam int unsigned N_DEFAULT = 16;

    // Index width for an n-bit vector; never below one bit so ports stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit encoder: bit 0 wins, idx is 0 when nothing is set.
// Also flags whether the vector is non-empty and whether at most one bit is set.
module lsb_prio_enc
    import req_enc_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         single
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] low_cleared;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? W'(i) : idx;
        end
    end

    // Removing the lowest set bit leaves zero exactly when popcount <= 1.
    always_comb begin
        low_cleared = vec & (vec - ONE);
        found       = |vec;
        single      = (low_cleared == '0);
    end

endmodule

// File: rtl/req_vector_encoder.sv
// Captures a multi-hot request vector and drains it as a stream of binary
// indices, lowest set bit first, one per output handshake.
module req_vector_encoder
    import req_enc_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_r;
    logic [N-1:0] pending_r;
    logic         zero_r;

    logic [W-1:0] enc_idx_s;
    logic         enc_found_s;
    logic         enc_single_s;
    logic         emit_s;
    logic         out_fire_s;

    lsb_prio_enc #(
        .N (N),
        .W (W)
    ) u_lsb_prio_enc (
        .vec    (pending_r),
        .idx    (enc_idx_s),
        .found  (enc_found_s),
        .single (enc_single_s)
    );

    // Output decode; everything is forced to zero outside EMIT.
    always_comb begin
        emit_s     = (state_r == ST_EMIT);
        out_fire_s = emit_s & out_ready;
        in_ready   = (state_r == ST_IDLE);
        out_valid  = emit_s;
        if (emit_s) begin
            out_idx  = enc_idx_s;
            out_last = enc_single_s;
            out_none = zero_r;
        end else begin
            out_idx  = '0;
            out_last = 1'b0;
            out_none = 1'b0;
        end
    end

    // State, pending vector and zero flag; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pending_r <= '0;
            zero_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r   <= ST_EMIT;
                        pending_r <= in_vec;
                        zero_r    <= (in_vec == '0);
                    end else begin
                        state_r   <= ST_IDLE;
                        pending_r <= pending_r;
                        zero_r    <= zero_r;
                    end
                end
                ST_EMIT: begin
                    if (out_fire_s && enc_single_s) begin
                        state_r   <= ST_IDLE;
                        pending_r <= '0;
                        zero_r    <= 1'b0;
                    end else if (out_fire_s) begin
                        // found is implied here: a non-single vector is never empty
                        state_r   <= ST_EMIT;
                        pending_r <= pending_r & (pending_r - ONE);
                        zero_r    <= zero_r & ~enc_found_s;
                    end else begin
                        state_r   <= ST_EMIT;
                        pending_r <= pending_r;
                        zero_r    <= zero_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pending_r <= '0;
                    zero_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_vector_encoder.sv
// Scoreboard bench for req_vector_encoder: directed vectors push hand-computed
// beats into a queue, and a monitor pops and compares on every output handshake.
module tb_req_vector_encoder;

    localparam int N = 16;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         last;
        logic         none;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;

    int    checks;
    int    failures;
    beat_t exp_q[$];

    req_vector_encoder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] idx, input logic last, input logic none);
        beat_t b;
        b.idx  = idx;
        b.last = last;
        b.none = none;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [N-1:0] vec);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_vec   = vec;
        tick();
        in_valid = 1'b0;
        in_vec   = '0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (!in_ready && cycles < budget) begin
            tick();
            cycles++;
        end
        check("idle_reached", {31'd0, in_ready}, 32'd1);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got idx=%0d last=%0b none=%0b expected no beat",
                             out_idx, out_last, out_none);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_idx", {28'd0, out_idx}, {28'd0, e.idx});
                    check("beat_last", {31'd0, out_last}, {31'd0, e.last});
                    check("beat_none", {31'd0, out_none}, {31'd0, e.none});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_idx", {28'd0, out_idx}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_none", {31'd0, out_none}, 32'd0);
        rst = 1'b0;
        tick();

        // 8421: four beats, back-to-back, then idle
        push(4'd0, 1'b0, 1'b0);
        push(4'd5, 1'b0, 1'b0);
        push(4'd10, 1'b0, 1'b0);
        push(4'd15, 1'b1, 1'b0);
        send(16'h8421);
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("emit_not_ready", {31'd0, in_ready}, 32'd0);
        wait_idle(20, cyc);
        check("drain_8421_cycles", cyc, 32'd4);
        check("q_empty_8421", exp_q.size(), 32'd0);

        // zero vector: one beat flagged none
        push(4'd0, 1'b1, 1'b1);
        send(16'h0000);
        wait_idle(20, cyc);
        check("drain_zero_cycles", cyc, 32'd1);
        check("idle_out_none", {31'd0, out_none}, 32'd0);

        // backpressure: beat holds while out_ready is low
        out_ready = 1'b0;
        push(4'd1, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0);
        send(16'h0006);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_idx", {28'd0, out_idx}, 32'd1);
            check("bp_last", {31'd0, out_last}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(20, cyc);
        check("drain_0006_cycles", cyc, 32'd2);

        // reset after the first handshake of FFFF
        push(4'd0, 1'b0, 1'b0);
        send(16'hFFFF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("q_empty_rst", exp_q.size(), 32'd0);
        push(4'd8, 1'b1, 1'b0);
        send(16'h0100);
        wait_idle(20, cyc);
        check("drain_0100_cycles", cyc, 32'd1);

        // in_valid during EMIT is ignored
        push(4'd0, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0);
        out_ready = 1'b0;
        send(16'h0003);
        in_valid = 1'b1;
        in_vec   = 16'h0010;
        tick();
        in_valid = 1'b0;
        in_vec   = '0;
        out_ready = 1'b1;
        wait_idle(20, cyc);
        check("drain_0003_cycles", cyc, 32'd2);
        tick();
        tick();
        check("no_recapture_valid", {31'd0, out_valid}, 32'd0);
        check("q_empty_final", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
